imem_load_ctrl: RTL and testbench
=================================

# imem_load_ctrl

Controller that owns the 128-byte instruction memory (IM) port. After reset it holds the fetch stage stalled, loads a program image from a byte stream into IM, then switches to RUN. In RUN it gates IM read enables for the pipeline and flags fetches that are misaligned or fall outside the loaded image. It sits between the boot/debug byte source, the IM write port and the IF stage.

## Interface
Parameters:
- IM_BYTES, 128, IM capacity in bytes
- IM_AW, 7, IM byte-address width (log2 IM_BYTES)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- load_req  in  1  request (re)load of the image; sampled each cycle
- ld_valid  in  1  byte-stream beat valid
- ld_data  in  8  byte-stream payload, image byte order (address 0 first)
- ld_last  in  1  marks final byte of image, qualified by ld_valid
- ld_ready  out  1  controller accepts a beat this cycle
- mem_we  out  1  IM byte write enable
- mem_waddr  out  IM_AW  IM byte write address
- mem_wdata  out  8  IM byte write data
- fetch_req  in  1  IF stage wants an instruction this cycle
- pc  in  32  fetch byte address
- im_read_en  out  1  IM read enable to IM
- fetch_stall  out  1  IF must hold pc
- img_len  out  IM_AW+1  bytes loaded (0..IM_BYTES)
- ovf  out  1  sticky: image exceeded IM_BYTES
- pc_fault  out  1  sticky: illegal fetch seen in RUN

## Operation
- States: IDLE, LOAD, DONE, RUN. Reset -> IDLE.
- IDLE: ld_ready=0; load_req -> LOAD, clear wr counter, img_len, ovf, pc_fault.
- LOAD: ld_ready=1. Beat = ld_valid & ld_ready. Each beat: if img_len < IM_BYTES, write byte at address img_len, img_len += 1; else byte dropped, ovf set, img_len held at IM_BYTES. Beat with ld_last -> DONE.
- DONE: single cycle, ld_ready=0, lets final write retire -> RUN.
- RUN: ld_ready=0. load_req -> LOAD with same clears as IDLE. load_req in LOAD/DONE ignored.
- im_read_en = fetch_req & (state==RUN) & legal, legal = (pc[1:0]==0) & (pc[31:IM_AW]==0) & (pc[IM_AW-1:0]+4 <= img_len) (sum computed in IM_AW+1 bits, no wrap).
- fetch_stall = fetch_req & (state!=RUN). Illegal fetch in RUN: no stall, im_read_en=0, pc_fault set next edge.
- ld_valid outside LOAD: ignored, no write, no state change.

## Timing
- Reset values: state IDLE; ld_ready, mem_we, mem_waddr, mem_wdata, img_len, ovf, pc_fault all 0. fetch_stall, im_read_en follow combinational rules (stall=fetch_req after reset).
- Write path registered: beat at edge N -> mem_we=1 with addr/data during cycle N..N+1 (one cycle). Back-to-back beats give back-to-back writes.
- ld_last beat at edge N: DONE in cycle after N, RUN one cycle later; first legal im_read_en two cycles after last beat.
- im_read_en, fetch_stall: zero-cycle combinational from fetch_req/pc/state.
- ld_last on a dropped (overflow) beat still ends LOAD.
- rstn low mid-load: next edge IDLE, image invalid (img_len=0); partially written IM contents not cleared.

## Structure
- Package imem_pkg: state enum (IDLE, LOAD, DONE, RUN), IM_BYTES, IM_AW constants shared with IM.
- Single module; no sub-module warranted (write stage is three registers).

## Test plan
- Reset, fetch_req=1 -> fetch_stall=1, im_read_en=0, ld_ready=0, all registered outputs 0.
- load_req, stream 8 bytes 0x00..0x07 with ld_last on 8th -> 8 writes addr 0..7, img_len=8, RUN 2 cycles after last beat; fetch pc=0x4 -> im_read_en=1; pc=0x8 -> im_read_en=0, pc_fault=1.
- Fetch pc=0x2 in RUN -> im_read_en=0, pc_fault=1, fetch_stall=0; pc=0x80 -> pc_fault path likewise.
- Stream 130 bytes -> 128 writes addr 0..127, last two dropped, img_len=128, ovf=1; fetch pc=0x7C legal.
- ld_valid gaps mid-stream (valid low 3 cycles) -> no writes during gaps, addresses contiguous; load_req during LOAD ignored.
- rstn low after 5 beats -> IDLE, img_len=0; reload from RUN via load_req clears pc_fault and ovf.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the IM itself:
// memory geometry and the loader state encoding.
package imem_pkg;

    localparam int IM_BYTES = 128;
    localparam int IM_AW    = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller. Holds fetch stalled after reset, copies
// a byte-stream image into IM, then runs the pipeline while screening fetches
// against alignment and the loaded image length.
module imem_load_ctrl #(
    parameter int IM_BYTES = imem_pkg::IM_BYTES,
    parameter int IM_AW    = imem_pkg::IM_AW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_req,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             mem_we,
    output logic [IM_AW-1:0] mem_waddr,
    output logic [7:0]       mem_wdata,
    input  logic             fetch_req,
    input  logic [31:0]      pc,
    output logic             im_read_en,
    output logic             fetch_stall,
    output logic [IM_AW:0]   img_len,
    output logic             ovf,
    output logic             pc_fault
);

    import imem_pkg::*;

    localparam logic [IM_AW:0] CAP_BYTES  = (IM_AW+1)'(IM_BYTES);
    localparam logic [IM_AW:0] WORD_BYTES = (IM_AW+1)'(4);

    state_e           state_q,     state_d;
    logic [IM_AW:0]   img_len_q,   img_len_d;
    logic             ovf_q,       ovf_d;
    logic             pc_fault_q,  pc_fault_d;
    logic             mem_we_q,    mem_we_d;
    logic [IM_AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;

    logic run_s;
    logic beat_s;
    logic legal_s;

    // Fetch screening and handshake decode; the end-of-word sum is one bit
    // wider than the address so a fetch at the top of IM cannot wrap.
    always_comb begin
        run_s    = (state_q == ST_RUN);
        ld_ready = (state_q == ST_LOAD);
        beat_s   = ld_valid & ld_ready;
        legal_s  = (pc[1:0] == 2'b00)
                 && (pc[31:IM_AW] == {(32-IM_AW){1'b0}})
                 && (({1'b0, pc[IM_AW-1:0]} + WORD_BYTES) <= img_len_q);
        im_read_en  = fetch_req & run_s & legal_s;
        fetch_stall = fetch_req & ~run_s;
    end

    // Next-state logic for the loader FSM, write stage and sticky flags.
    always_comb begin
        state_d     = state_q;
        img_len_d   = img_len_q;
        ovf_d       = ovf_q;
        pc_fault_d  = pc_fault_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d    = ST_LOAD;
                    img_len_d  = '0;
                    ovf_d      = 1'b0;
                    pc_fault_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    if (img_len_q < CAP_BYTES) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = img_len_q[IM_AW-1:0];
                        mem_wdata_d = ld_data;
                        img_len_d   = img_len_q + {{IM_AW{1'b0}}, 1'b1};
                    end else begin
                        // Image larger than IM: drop the byte, keep length saturated.
                        ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                // One idle cycle so the final registered write retires before fetch.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fetch_req && !legal_s) begin
                    pc_fault_d = 1'b1;
                end else begin
                    pc_fault_d = pc_fault_q;
                end
                if (load_req) begin
                    state_d    = ST_LOAD;
                    img_len_d  = '0;
                    ovf_d      = 1'b0;
                    pc_fault_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            img_len_q   <= '0;
            ovf_q       <= 1'b0;
            pc_fault_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            img_len_q   <= img_len_d;
            ovf_q       <= ovf_d;
            pc_fault_q  <= pc_fault_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign img_len   = img_len_q;
    assign ovf       = ovf_q;
    assign pc_fault  = pc_fault_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: fetch-screening vector table plus
// hand-written load, gap, overflow, reload and reset sequences.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        load_req;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        mem_we;
    logic [6:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        fetch_req;
    logic [31:0] pc;
    logic        im_read_en;
    logic        fetch_stall;
    logic [7:0]  img_len;
    logic        ovf;
    logic        pc_fault;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        fr;
        logic [31:0] pc;
        logic        exp_rd;
        logic        exp_stall;
        logic        exp_fault;
    } fvec_t;

    fvec_t fv[9];

    imem_load_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .load_req   (load_req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .im_read_en (im_read_en),
        .fetch_stall(fetch_stall),
        .img_len    (img_len),
        .ovf        (ovf),
        .pc_fault   (pc_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load_req for one edge; controller is in LOAD afterwards.
    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // One accepted beat; checks the registered write that results from it.
    task automatic beat(input logic [7:0] d, input logic last,
                        input logic exp_we, input logic [6:0] exp_addr);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("beat_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_we) begin
            chk("beat_addr", {25'd0, mem_waddr}, {25'd0, exp_addr});
            chk("beat_data", {24'd0, mem_wdata}, {24'd0, d});
        end
    endtask

    initial begin
        fv[0] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        fv[1] = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0};
        fv[2] = '{1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        fv[3] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1};
        fv[4] = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1};
        fv[5] = '{1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1};
        fv[6] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        fv[7] = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b1};
        fv[8] = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b1};

        rstn = 1'b0; load_req = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        ld_last = 1'b0; fetch_req = 1'b1; pc = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_stall",   {31'd0, fetch_stall}, 32'd1);
        chk("rst_rd_en",   {31'd0, im_read_en},  32'd0);
        chk("rst_ready",   {31'd0, ld_ready},    32'd0);
        chk("rst_we",      {31'd0, mem_we},      32'd0);
        chk("rst_waddr",   {25'd0, mem_waddr},   32'd0);
        chk("rst_wdata",   {24'd0, mem_wdata},   32'd0);
        chk("rst_img_len", {24'd0, img_len},     32'd0);
        chk("rst_ovf",     {31'd0, ovf},         32'd0);
        chk("rst_fault",   {31'd0, pc_fault},    32'd0);

        // 8-byte image
        rstn = 1'b1;
        tick();
        chk("idle_ready", {31'd0, ld_ready}, 32'd0);
        start_load();
        chk("load_ready", {31'd0, ld_ready}, 32'd1);
        chk("load_stall", {31'd0, fetch_stall}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            beat(8'(i), (i == 7), 1'b1, 7'(i));
        end
        chk("done_ready",   {31'd0, ld_ready},    32'd0);
        chk("done_stall",   {31'd0, fetch_stall}, 32'd1);
        chk("done_img_len", {24'd0, img_len},     32'd8);
        tick();
        chk("run_we",    {31'd0, mem_we},      32'd0);
        chk("run_stall", {31'd0, fetch_stall}, 32'd0);
        chk("run_rd_en", {31'd0, im_read_en},  32'd1);

        // Stray stream beat in RUN is ignored
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 8'hEE;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("stray_we",    {31'd0, mem_we},      32'd0);
        chk("stray_stall", {31'd0, fetch_stall}, 32'd0);

        // Fetch screening table against img_len=8
        for (int i = 0; i < 9; i++) begin
            fetch_req = fv[i].fr;
            pc        = fv[i].pc;
            #1;
            chk($sformatf("fv%0d_rd_en", i), {31'd0, im_read_en},  {31'd0, fv[i].exp_rd});
            chk($sformatf("fv%0d_stall", i), {31'd0, fetch_stall}, {31'd0, fv[i].exp_stall});
            @(posedge clk);
            #1;
            chk($sformatf("fv%0d_fault", i), {31'd0, pc_fault}, {31'd0, fv[i].exp_fault});
        end

        // Reload from RUN with ld_valid gaps and an ignored load_req
        fetch_req = 1'b0; pc = 32'h0;
        start_load();
        chk("reload_fault",   {31'd0, pc_fault}, 32'd0);
        chk("reload_img_len", {24'd0, img_len},  32'd0);
        for (int i = 0; i < 3; i++) begin
            beat(8'hA0 + 8'(i), 1'b0, 1'b1, 7'(i));
        end
        for (int g = 0; g < 3; g++) begin
            load_req = (g == 1);
            tick();
            chk("gap_we",      {31'd0, mem_we},   32'd0);
            chk("gap_img_len", {24'd0, img_len},  32'd3);
            chk("gap_ready",   {31'd0, ld_ready}, 32'd1);
        end
        load_req = 1'b0;
        for (int i = 3; i < 6; i++) begin
            beat(8'hA0 + 8'(i), (i == 5), 1'b1, 7'(i));
        end
        tick();
        chk("gap_img_len_end", {24'd0, img_len}, 32'd6);
        fetch_req = 1'b1; pc = 32'h0;
        #1;
        chk("len6_pc0_rd", {31'd0, im_read_en}, 32'd1);
        pc = 32'h4;
        #1;
        chk("len6_pc4_rd", {31'd0, im_read_en}, 32'd0);
        fetch_req = 1'b0;
        tick();
        chk("len6_pc4_fault", {31'd0, pc_fault}, 32'd0);
        fetch_req = 1'b1; pc = 32'h2;
        #1;
        chk("misalign_rd",    {31'd0, im_read_en},  32'd0);
        chk("misalign_stall", {31'd0, fetch_stall}, 32'd0);
        tick();
        chk("misalign_fault", {31'd0, pc_fault}, 32'd1);
        fetch_req = 1'b0;

        // 130-byte image overflows IM
        start_load();
        chk("ovf_start_fault", {31'd0, pc_fault}, 32'd0);
        for (int i = 0; i < 130; i++) begin
            beat(8'(i ^ 8'h5A), (i == 129), (i < 128), 7'(i));
            chk("ovf_flag", {31'd0, ovf}, {31'd0, (i >= 128)});
        end
        chk("ovf_img_len", {24'd0, img_len}, 32'd128);
        tick();
        fetch_req = 1'b1; pc = 32'h7C;
        #1;
        chk("ovf_pc7c_rd", {31'd0, im_read_en}, 32'd1);
        pc = 32'h80;
        #1;
        chk("ovf_pc80_rd", {31'd0, im_read_en}, 32'd0);
        tick();
        chk("ovf_pc80_fault", {31'd0, pc_fault}, 32'd1);
        fetch_req = 1'b0;

        // Reload clears flags; reset mid-load invalidates image
        start_load();
        chk("clr_ovf",   {31'd0, ovf},      32'd0);
        chk("clr_fault", {31'd0, pc_fault}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            beat(8'h30 + 8'(i), 1'b0, 1'b1, 7'(i));
        end
        chk("pre_rst_len", {24'd0, img_len}, 32'd5);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        fetch_req = 1'b1;
        #1;
        chk("midrst_len",   {24'd0, img_len},     32'd0);
        chk("midrst_ready", {31'd0, ld_ready},    32'd0);
        chk("midrst_stall", {31'd0, fetch_stall}, 32'd1);
        chk("midrst_we",    {31'd0, mem_we},      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
